// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   forward_sel_t : EX operand source select (regfile / WB result / ALUResultM)
//   mem_state_t   : data-memory wait FSM states
//   REG_ZERO      : architectural x0, never forwarded or hazard-checked
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } forward_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Operand source for one EX source register; the MEM stage result is younger, so it wins.
  function automatic forward_sel_t fwd_select(input logic [4:0] rs,
                                              input logic [4:0] rd_m,
                                              input logic       reg_write_m,
                                              input logic [4:0] rd_w,
                                              input logic       reg_write_w);
    if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
      return FWD_M;
    end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding selects (purely combinational).
// Ports:
//   Rs1E, Rs2E            : source registers of the instruction in Execute
//   RdM, RegWriteM        : destination / write enable in Memory
//   RdW, RegWriteW        : destination / write enable in Writeback
//   ForwardAE, ForwardBE  : operand select for ALU source A / B
module hazard_forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0]   Rs1E,
  input  logic [4:0]   Rs2E,
  input  logic [4:0]   RdM,
  input  logic         RegWriteM,
  input  logic [4:0]   RdW,
  input  logic         RegWriteW,
  output forward_sel_t ForwardAE,
  output forward_sel_t ForwardBE
);

  always_comb begin
    ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline.
// Produces stall/flush enables for the pipeline registers, EX forwarding selects, and
// holds the whole pipeline while a multi-cycle data-memory access in MEM is outstanding.
// Ports:
//   clk, rst_n                       : clock (rising edge), async active-low reset
//   Rs1D, Rs2D / Rs1E, Rs2E          : source registers in Decode / Execute
//   RdE, RdM, RdW                    : destination registers in E / M / W
//   ResultSrcE                       : instruction in E is a load
//   RegWriteM, RegWriteW             : register write enables in M / W
//   PCSrcE                           : taken branch/jump resolved in E
//   MemReqM, MemReadyM               : data-memory request active / acknowledged
//   StallF/D/E/M                     : hold PC, IF-ID, ID-EX, EX-MEM
//   FlushD/E/W                       : bubble into IF-ID, ID-EX, MEM-WB
//   ForwardAE, ForwardBE             : operand select (00 regfile, 01 WB, 10 ALUResultM)
//   MemErr                           : sticky memory timeout flag
// Optional build macro HAZARD_PERF_EN adds saturating StallCycles / FlushCount counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        ResultSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  forward_sel_t fwd_a, fwd_b;
  logic         load_use;
  logic         mem_hold;

  hazard_forward_unit u_forward (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .ForwardAE (fwd_a),
    .ForwardBE (fwd_b)
  );

  // Memory wait FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          state_d = WAIT;
          cnt_d   = CntOne;
        end
      end
      WAIT: begin
        // A dropped MemReqM here is illegal; keep counting so it still times out.
        if (MemReadyM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Hazard decode.
  always_comb begin
    load_use = ResultSrcE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
    // Combinational so the freeze lands in the very cycle the access is seen unacknowledged.
    mem_hold = (state_q == ERR) || (MemReqM && !MemReadyM);
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    if (rst_n) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mem_hold) begin
        // E is frozen, so any branch/load-use flush is re-applied on the release cycle.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        // A taken branch squashes the load-use victim, so no stall is needed.
        StallF = load_use && !PCSrcE;
        StallD = load_use && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = PCSrcE || load_use;
        FlushW = 1'b0;
      end
    end
  end

  assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (FlushE && !mem_hold && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by randomized
// traffic, all outputs compared each cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model state: access outstanding, consecutive unacknowledged cycles, sticky error.
  bit m_busy;
  int m_unacked;
  bit m_err;
  int m_sc, m_fc;
  bit e_stallf, e_flushe, e_hold;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .ResultSrcE (ResultSrcE),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .MemErr     (MemErr)
`ifdef HAZARD_PERF_EN
    ,
    .StallCycles(StallCycles),
    .FlushCount (FlushCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_unacked = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_outputs();
    bit lu, br, sfd, fd, fe, fw, se;
    logic [1:0] fa, fb;
    if (!rst_n) begin
      {sfd, se, fd, fe, fw, fa, fb} = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
      e_hold = 0;
    end else begin
      lu     = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      br     = PCSrcE;
      e_hold = m_err || (MemReqM && !MemReadyM);
      sfd    = e_hold || (lu && !br);
      se     = e_hold;
      fd     = !e_hold && br;
      fe     = !e_hold && (br || lu);
      fw     = e_hold;
      fa     = ref_fwd(Rs1E);
      fb     = ref_fwd(Rs2E);
    end
    e_stallf = sfd;
    e_flushe = fe;
    check("StallF", StallF, sfd);
    check("StallD", StallD, sfd);
    check("StallE", StallE, se);
    check("StallM", StallM, se);
    check("FlushD", FlushD, fd);
    check("FlushE", FlushE, fe);
    check("FlushW", FlushW, fw);
    check("ForwardAE", ForwardAE, fa);
    check("ForwardBE", ForwardBE, fb);
    check("MemErr", MemErr, m_err);
`ifdef HAZARD_PERF_EN
    check("StallCycles", StallCycles, m_sc);
    check("FlushCount", FlushCount, m_fc);
`endif
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (e_stallf) m_sc++;
    if (e_flushe && !e_hold) m_fc++;
    if (m_err) return;
    if (!m_busy) begin
      if (MemReqM && !MemReadyM) begin
        m_busy = 1;
        m_unacked = 1;
      end
    end else if (MemReadyM) begin
      m_busy = 0;
      m_unacked = 0;
    end else begin
      m_unacked++;
      if (m_unacked > TO) m_err = 1;
    end
  endtask

  // Inputs are set just after a rising edge; half() checks at the falling edge.
  task automatic half();
    if (!rst_n) model_reset();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    half();
    finish_cycle();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Performance scenario: two load-use stalls then a 3-cycle memory wait.
    ResultSrcE = 1; RdE = 7; Rs2D = 7;
    repeat (2) step();
    clear_inputs();
    MemReqM = 1;
    repeat (3) step();
    MemReadyM = 1;
    step();
    clear_inputs();
    half();
`ifdef HAZARD_PERF_EN
    check("plan_stall_cycles", StallCycles, 32'd5);
    check("plan_flush_count", FlushCount, 32'd2);
`endif
    finish_cycle();
    do_reset();

    // Forwarding priority.
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    half();
    check("plan_fwdA_M", ForwardAE, 2'b10);
    check("plan_fwdB_x0", ForwardBE, 2'b00);
    finish_cycle();
    RegWriteM = 0;
    half();
    check("plan_fwdA_W", ForwardAE, 2'b01);
    finish_cycle();
    clear_inputs();

    // Load-use, then the x0 case.
    ResultSrcE = 1; RdE = 7; Rs2D = 7;
    half();
    check("plan_lu_stall", {StallF, StallD, FlushE}, 3'b111);
    finish_cycle();
    RdE = 0; Rs2D = 0;
    half();
    check("plan_lu_x0", {StallF, StallD, FlushE}, 3'b000);
    finish_cycle();

    // Branch beats load-use.
    RdE = 7; Rs2D = 7; PCSrcE = 1;
    half();
    check("plan_br_lu", {FlushD, FlushE, StallF, StallD}, 4'b1100);
    finish_cycle();
    clear_inputs();

    // Three-cycle memory wait.
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      half();
      check("plan_wait_hold", {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
      finish_cycle();
    end
    MemReadyM = 1;
    half();
    check("plan_wait_release", {StallF, StallE, StallM, FlushW}, 4'b0000);
    finish_cycle();
    clear_inputs();
    step();

    // Timeout into ERR, then asynchronous reset mid-ERR.
    MemReqM = 1;
    for (int i = 0; i < 5; i++) begin
      half();
      check("plan_to_noerr", MemErr, 1'b0);
      finish_cycle();
    end
    MemReadyM = 1;
    half();
    check("plan_to_err", MemErr, 1'b1);
    check("plan_to_stall", {StallF, StallE, FlushW}, 3'b111);
    finish_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("plan_rst_memerr", MemErr, 1'b0);
    check("plan_rst_outs", {StallF, StallM, FlushD, FlushE, FlushW}, 5'b00111);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 79) != 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultSrcE = 1'($urandom);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = ($urandom_range(0, 2) == 0) || m_busy;
      MemReadyM  = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
